// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID pipeline register, field/immediate decode,
// 32x32 register file with write-through bypass from the writeback port.
module id_stage #(
  parameter int              XLEN = 32,
  parameter int              PC_W = 10,
  parameter logic [XLEN-1:0] NOP  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            taken,
  input  logic            halting,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            illegal
);

  logic [XLEN-1:0] inst_r;
  logic [PC_W-1:0] pc_r;
  logic            valid_r;
  logic [XLEN-1:0] regs_r [0:31];
  logic            wb_hit_s;

  function automatic logic [XLEN-1:0] imm_gen(input logic [XLEN-1:0] ins);
    logic [XLEN-1:0] res;
    res = {XLEN{1'b0}};
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        res = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        res = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        res = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        res = {ins[31:12], 12'h000};
      7'b1101111:
        res = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // IF/ID register: flush beats stall; a flush still advances the PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r  <= NOP;
      pc_r    <= {PC_W{1'b0}};
      valid_r <= 1'b0;
    end else if (taken) begin
      inst_r  <= NOP;
      pc_r    <= pc_i;
      valid_r <= 1'b0;
    end else if (!halting) begin
      inst_r  <= inst_i;
      pc_r    <= pc_i;
      valid_r <= 1'b1;
    end
  end

  // Register file write port; x0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= {XLEN{1'b0}};
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  assign id_valid  = valid_r;
  assign id_pc     = pc_r;
  assign opcode    = inst_r[6:0];
  assign rd        = inst_r[11:7];
  assign funct3    = inst_r[14:12];
  assign rs1       = inst_r[19:15];
  assign rs2       = inst_r[24:20];
  assign funct7_b5 = inst_r[30];
  assign imm       = imm_gen(inst_r);
  assign illegal   = valid_r & ~op_supported(inst_r[6:0]);
  assign wb_hit_s  = wb_we && (wb_rd != 5'd0);

  // Combinational reads with same-cycle bypass of the writeback value
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs2_data = {XLEN{1'b0}};
    if (rs1 == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end else if (wb_hit_s && (wb_rd == rs1)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end else if (wb_hit_s && (wb_rd == rs2)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_r[rs2];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected decode results into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_i = 32'h0;
  logic [9:0]  pc_i = 10'd0;
  logic        taken = 1'b0;
  logic        halting = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        id_valid, funct7_b5, illegal;
  logic [9:0]  id_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_data, rs2_data;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .pc_i(pc_i), .taken(taken),
    .halting(halting), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7_b5(funct7_b5), .imm(imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [9:0]  pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;

  // Reference model state
  logic [31:0] m_inst;
  logic [9:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_regs [32];
  logic [6:0]  legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 32'($signed(i[31:20]));
      7'h23:               return 32'($signed({i[31:25], i[11:7]}));
      7'h63:               return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17:        return {i[31:12], 12'h000};
      7'h6F:               return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    m_inst = 32'h0000_0013;
    m_pc = 10'd0;
    m_valid = 1'b0;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
  endtask

  // Applies the clock edge that just happened, using the inputs that were held over it
  task automatic model_edge();
    if (rst_n) begin
      if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (taken) begin
        m_inst = 32'h0000_0013; m_pc = pc_i; m_valid = 1'b0;
      end else if (!halting) begin
        m_inst = inst_i; m_pc = pc_i; m_valid = 1'b1;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.valid = m_valid;
    e.pc    = m_pc;
    e.op    = m_inst[6:0];
    e.rd    = m_inst[11:7];
    e.f3    = m_inst[14:12];
    e.rs1   = m_inst[19:15];
    e.rs2   = m_inst[24:20];
    e.f7b5  = m_inst[30];
    e.imm   = ref_imm(m_inst);
    e.r1    = ref_read(e.rs1);
    e.r2    = ref_read(e.rs2);
    e.ill   = m_valid && !(m_inst[6:0] inside {legal_ops});
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [31:0] ins, input logic [9:0] pc,
                      input logic tk, input logic hl, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wd);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = rst; inst_i = ins; pc_i = pc; taken = tk; halting = hl;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    if (!rst) model_reset();
    push_expected();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: the stage presents a decode result every cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("id_valid", 32'(id_valid), 32'(e.valid));
      check("id_pc", 32'(id_pc), 32'(e.pc));
      check("opcode", 32'(opcode), 32'(e.op));
      check("rd", 32'(rd), 32'(e.rd));
      check("rs1", 32'(rs1), 32'(e.rs1));
      check("rs2", 32'(rs2), 32'(e.rs2));
      check("funct3", 32'(funct3), 32'(e.f3));
      check("funct7_b5", 32'(funct7_b5), 32'(e.f7b5));
      check("imm", imm, e.imm);
      check("rs1_data", rs1_data, e.r1);
      check("rs2_data", rs2_data, e.r2);
      check("illegal", 32'(illegal), 32'(e.ill));
    end
  end

  initial begin
    logic [31:0] ri;
    logic [6:0]  rop;
    model_reset();
    step(1'b0, 32'h0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h0, 10'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // addi x1,x0,5 then add x2,x1,x1 with bypassed writeback of x1
    step(1'b1, 32'h0050_0093, 10'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0010_8133, 10'd4, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0000_0013, 10'd5, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);
    // stall 3 cycles with changing inst_i, then release
    step(1'b1, 32'h0000_0033, 10'd6, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0020_0113, 10'd7, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0030_0193, 10'd8, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0040_0213, 10'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // flush together with stall
    step(1'b1, 32'hFE51_2E23, 10'd10, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'hFE51_2E23, 10'd11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'hFE00_0CE3, 10'd12, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0010_00EF, 10'd13, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h1234_51B7, 10'd14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0050_0093, 10'd15, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // write to x0 while reading x0, then an unsupported opcode
    step(1'b1, 32'h0000_007F, 10'd16, 1'b0, 1'b0, 1'b1, 5'd0, 32'd7);
    step(1'b1, 32'h0000_0013, 10'd17, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0010_8133, 10'd18, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // asynchronous reset mid-stream, observed before any further clock edge
    step(1'b0, 32'h0010_8133, 10'd19, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0010_8133, 10'd20, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 32'h0000_0013, 10'd21, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // randomized traffic with register indices kept small to exercise bypass
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
      else rop = legal_ops[$urandom_range(0, 10)];
      ri[6:0] = rop;
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 99) != 0), ri, 10'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
           1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly downstream of if_stage in the 5-stage RV32I pipeline.
- Holds the IF/ID pipeline register, capturing inst/pc from fetch.
- Honours the same taken (flush) and halting (stall) controls as fetch.
- Decodes RV32I fields, generates the immediate, reads the 32x32 register file and accepts the writeback port, with write-through bypass.

Parameters:
- XLEN, 32, data/instruction width.
- PC_W, 10, word-address PC width, matching the 1024-word imem.
- NOP, 32'h0000_0013, instruction injected on reset/flush (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inst_i  input  XLEN  instruction from if_stage, aligned with pc_i.
- pc_i  input  PC_W  word address of inst_i.
- taken  input  1  branch taken; flush IF/ID.
- halting  input  1  stall; hold IF/ID contents.
- wb_we  input  1  writeback enable.
- wb_rd  input  5  writeback destination.
- wb_data  input  XLEN  writeback value.
- id_valid  output  1  decoded instruction is real (not bubble).
- id_pc  output  PC_W  latched PC.
- opcode  output  7  inst[6:0].
- rd  output  5  inst[11:7].
- rs1  output  5  inst[19:15].
- rs2  output  5  inst[24:20].
- funct3  output  3  inst[14:12].
- funct7_b5  output  1  inst[30].
- imm  output  XLEN  sign-extended immediate.
- rs1_data  output  XLEN  register-file read 1.
- rs2_data  output  XLEN  register-file read 2.
- illegal  output  1  unsupported opcode while id_valid.

Behaviour:
- Reset (async, any time, including mid-operation):
  - IF/ID inst=NOP, pc=0, id_valid=0.
  - All 32 registers cleared to 0.
  - All outputs therefore decode NOP: rd=0, imm=0, rs*_data=0, illegal=0.
- IF/ID register update at each posedge, in priority order:
  - taken=1: inst<=NOP, id_valid<=0, pc<=pc_i. taken wins over halting when both are high.
  - Else halting=1: hold inst, pc and id_valid unchanged.
  - Else: inst<=inst_i, pc<=pc_i, id_valid<=1.
- Latency: inst_i presented in cycle N appears decoded in cycle N+1. All decode outputs are combinational from the latched instruction.
- Immediate, selected by opcode, all sign-extended from inst[31]:
  - I-type (0000011, 0010011, 1100111): inst[31:20].
  - S-type (0100011): {inst[31:25], inst[11:7]}.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: imm=0.
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write at posedge when wb_we=1 and wb_rd!=0.
  - Writes happen regardless of halting/taken; writeback is never stalled by this stage.
  - Reads are combinational.
  - Bypass: if wb_we=1, wb_rd!=0 and wb_rd==rs1 (or rs2), the corresponding rs*_data=wb_data in the same cycle.
- illegal = id_valid AND opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}.
- The flushed bubble decodes as NOP with id_valid=0 and never asserts illegal.
- The stage has no internal state machine beyond the valid bit. Stall/flush sequencing is owned by the hazard unit.

Test Plan:
- Reset then release; inst_i=32'h00500093 (addi x1,x0,5), pc_i=3 -> next cycle id_valid=1, id_pc=3, rd=1, rs1=0, imm=5, rs1_data=0, illegal=0.
- wb_we=1, wb_rd=1, wb_data=32'hDEADBEEF while inst latched is add x2,x1,x1 (32'h00108133) -> rs1_data=rs2_data=32'hDEADBEEF in the same cycle (bypass). The value persists after wb_we drops.
- Assert halting for 3 cycles with inst_i changing each cycle -> id_pc/inst outputs frozen, id_valid unchanged. Release -> next inst_i captured.
- taken=1 together with halting=1 -> next cycle id_valid=0, rd=0, imm=0, illegal=0.
- Immediate decode:
  - sw x5,-4(x2) (32'hFE512E23) -> imm=32'hFFFFFFFC.
  - beq x0,x0,-8 (32'hFE000CE3) -> imm=32'hFFFFFFF8.
  - jal x1,+2048 (32'h001000EF) -> imm=32'h00000800.
  - lui x3,0x12345 (32'h123451B7) -> imm=32'h12345000.
- Write wb_rd=0, wb_data=7, then read x0 -> rs1_data=0. inst_i=32'h0000007F -> illegal=1. Assert rst_n=0 mid-stream -> id_valid=0 immediately (asynchronous), registers read 0.
